// File: rtl/lts_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lts_capture_pkg                                              |
// | Description : Shared types and constants for the LTS capture control path. |
// |               state_t encoding is the value driven on state_out.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lts_capture_pkg;

   // Encoding is externally visible on state_out (LEDs / debug), keep it fixed.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SYNC_SHORT = 3'd1,
      SYNC_LONG  = 3'd2,
      HOLD       = 3'd3,
      DONE       = 3'd4
   } state_t;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

   // Width of a counter that must hold values 0..max_val-1, never below 1 bit.
   function automatic int idx_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lts_capture_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lts_capture_fifo                                             |
// | Description : Synchronous first-word-fall-through FIFO. A written word is  |
// |               visible on rd_data_out one cycle after the write. Exposes    |
// |               the free word count for frame admission control.             |
// | Ports       : clk_in/rst_in     clock, sync active-high reset              |
// |               wr_en_in/wr_data_in   push side                              |
// |               rd_en_in          pop request (effective only when valid)    |
// |               rd_valid_out/rd_data_out  head of queue (0 when empty)       |
// |               free_out          number of empty slots                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lts_capture_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 256
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       wr_en_in,
   input  logic [WIDTH-1:0]           wr_data_in,
   input  logic                       rd_en_in,
   output logic                       rd_valid_out,
   output logic [WIDTH-1:0]           rd_data_out,
   output logic [$clog2(DEPTH):0]     free_out
);

   localparam int                c_ADDR_W = $clog2(DEPTH);
   localparam logic [c_ADDR_W:0] c_DEPTH  = (c_ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [c_ADDR_W:0] r_wr_ptr;
   logic [c_ADDR_W:0] r_rd_ptr;

   logic [c_ADDR_W:0] w_count;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = w_count[c_ADDR_W];
   assign w_pop   = rd_en_in && !w_empty;
   // A push while full is accepted only when a pop frees the slot the same cycle.
   assign w_push  = wr_en_in && (!w_full || w_pop);

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= wr_data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Upstream reserves space before a frame starts, so an overflow is a design bug.
   always_ff @(posedge clk_in) begin
      if (!rst_in && wr_en_in) begin
         assert (!w_full || w_pop);
      end
   end

   assign rd_valid_out = !w_empty;
   assign rd_data_out  = w_empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
   assign free_out     = c_DEPTH - w_count;

endmodule
`default_nettype wire

// File: rtl/lts_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lts_capture_ctrl                                             |
// | Description : Sequences power_trigger -> sync_short -> sync_long, buffers  |
// |               each captured LTS frame in a FIFO and streams it over AXIS   |
// |               tagged with its frame index.                                 |
// | Ports       : clk_in/rst_in        clock, sync active-high reset           |
// |               mode_in/arm_in       0 continuous / 1 single-shot, re-arm    |
// |               signal_valid_in      input sample strobe (timeout count)     |
// |               power_trigger_in, short_detected_in   detector inputs        |
// |               sync_*_rst_out, short_en_out, long_en_out  detector control  |
// |               lts_*_in, lts_ready_out   LTS word stream from sync_long     |
// |               m_axis_*             buffered output stream, tuser=frame idx |
// |               state_out            encoded state                           |
// |               *_cnt_out            saturating status counters              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lts_capture_ctrl
   import lts_capture_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int LTS_LEN      = 128,
   parameter int FIFO_DEPTH   = 256,
   parameter int LONG_TIMEOUT = 320,
   parameter int HOLDOFF      = 64,
   parameter int CNT_W        = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              mode_in,
   input  logic              arm_in,
   input  logic              signal_valid_in,
   input  logic              power_trigger_in,
   input  logic              short_detected_in,
   output logic              sync_short_rst_out,
   output logic              sync_long_rst_out,
   output logic              short_en_out,
   output logic              long_en_out,
   input  logic              lts_valid_in,
   input  logic              lts_last_in,
   input  logic [DATA_W-1:0] lts_data_in,
   output logic              lts_ready_out,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [CNT_W-1:0]  m_axis_tuser,
   input  logic              m_axis_tready,
   output logic [2:0]        state_out,
   output logic [CNT_W-1:0]  frame_cnt_out,
   output logic [CNT_W-1:0]  drop_cnt_out,
   output logic [CNT_W-1:0]  timeout_cnt_out
);

   localparam int c_FIFO_W = 1 + CNT_W + DATA_W;
   localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
   localparam int c_SMP_W  = $clog2(LONG_TIMEOUT + 1);
   localparam int c_WRD_W  = idx_width(LTS_LEN);
   localparam int c_HLD_W  = idx_width(HOLDOFF);

   localparam logic [c_SMP_W-1:0]  c_SMP_LIMIT   = c_SMP_W'(LONG_TIMEOUT);
   localparam logic [c_WRD_W-1:0]  c_WRD_LAST    = c_WRD_W'(LTS_LEN - 1);
   localparam logic [c_HLD_W-1:0]  c_HLD_LAST    = c_HLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [c_ADDR_W:0]   c_LTS_RESERVE = (c_ADDR_W+1)'(LTS_LEN);

   state_t               r_state;
   state_t               w_next;
   state_t               w_rest_state;
   state_t               w_post_state;

   logic [c_SMP_W-1:0]   r_sample_cnt;
   logic [c_WRD_W-1:0]   r_word_cnt;
   logic [c_HLD_W-1:0]   r_hold_cnt;
   logic                 r_started;
   logic [CNT_W-1:0]     r_frame_idx;
   logic [CNT_W-1:0]     r_frame_cnt;
   logic [CNT_W-1:0]     r_drop_cnt;
   logic [CNT_W-1:0]     r_timeout_cnt;
   logic                 r_short_rst;
   logic                 r_long_rst;

   logic                 w_wr;
   logic                 w_last;
   logic                 w_frame_end;
   logic                 w_admit;
   logic                 w_short_hit;
   logic                 w_enter_short;
   logic                 w_enter_long;
   logic                 w_drop;
   logic                 w_timed_out;
   logic                 w_abort;
   logic                 w_timeout_evt;

   logic [c_ADDR_W:0]    w_fifo_free;
   logic [c_FIFO_W-1:0]  w_fifo_wdata;
   logic [c_FIFO_W-1:0]  w_fifo_rdata;
   logic                 w_fifo_valid;

   // ------------------------------------------------------------------------
   // Event decode
   // ------------------------------------------------------------------------
   assign w_wr          = lts_valid_in && (r_state == SYNC_LONG);
   assign w_last        = lts_last_in || (r_word_cnt == c_WRD_LAST);
   assign w_frame_end   = w_wr && w_last;
   // A frame is only started if the whole worst-case frame fits already.
   assign w_admit       = (w_fifo_free >= c_LTS_RESERVE);
   assign w_enter_short = (r_state == IDLE) && power_trigger_in;
   assign w_short_hit   = (r_state == SYNC_SHORT) && short_detected_in;
   assign w_enter_long  = w_short_hit && w_admit;
   assign w_drop        = w_short_hit && !w_admit;
   assign w_timed_out   = (r_sample_cnt == c_SMP_LIMIT);
   // Abort is only possible before the first word; an arriving first word wins.
   assign w_abort       = (r_state == SYNC_LONG) && !r_started && !w_wr &&
                          (!power_trigger_in || w_timed_out);
   assign w_timeout_evt = w_abort && w_timed_out;

   assign w_rest_state  = (mode_in == MODE_SINGLE) ? DONE : IDLE;

   generate
      if (HOLDOFF == 0) begin : g_no_hold
         assign w_post_state = w_rest_state;
      end else begin : g_hold
         assign w_post_state = HOLD;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (power_trigger_in) w_next = SYNC_SHORT;
         end
         SYNC_SHORT: begin
            // Detection takes priority over a simultaneous power drop.
            if (short_detected_in)      w_next = w_admit ? SYNC_LONG : w_post_state;
            else if (!power_trigger_in) w_next = IDLE;
         end
         SYNC_LONG: begin
            if (w_frame_end || w_abort) w_next = w_post_state;
         end
         HOLD: begin
            if (r_hold_cnt == c_HLD_LAST) w_next = w_rest_state;
         end
         DONE: begin
            if (arm_in) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Frame-level counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sample_cnt <= '0;
         r_word_cnt   <= '0;
         r_started    <= 1'b0;
         r_hold_cnt   <= '0;
         r_short_rst  <= 1'b0;
         r_long_rst   <= 1'b0;
      end else begin
         r_short_rst <= w_enter_short;
         r_long_rst  <= w_enter_long;

         if (w_enter_long) begin
            r_sample_cnt <= '0;
            r_word_cnt   <= '0;
            r_started    <= 1'b0;
         end else begin
            // Sample counting stops at the limit and once the frame has begun.
            if (r_state == SYNC_LONG && !r_started && signal_valid_in && !w_timed_out) begin
               r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (w_wr) begin
               r_word_cnt <= r_word_cnt + 1'b1;
               r_started  <= 1'b1;
            end
         end

         if (r_state == HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
         else                 r_hold_cnt <= '0;
      end
   end

   // ------------------------------------------------------------------------
   // Frame index (wrapping) and saturating status counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_frame_idx   <= '0;
         r_frame_cnt   <= '0;
         r_drop_cnt    <= '0;
         r_timeout_cnt <= '0;
      end else begin
         if (w_frame_end) begin
            r_frame_idx <= r_frame_idx + 1'b1;
            if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
         end
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
         if (w_timeout_evt && (r_timeout_cnt != '1)) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------------
   assign w_fifo_wdata = {w_last, r_frame_idx, lts_data_in};

   lts_capture_fifo #(
      .WIDTH (c_FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .wr_en_in     (w_wr),
      .wr_data_in   (w_fifo_wdata),
      .rd_en_in     (m_axis_tready),
      .rd_valid_out (w_fifo_valid),
      .rd_data_out  (w_fifo_rdata),
      .free_out     (w_fifo_free)
   );

   assign m_axis_tvalid = w_fifo_valid;
   assign m_axis_tlast  = w_fifo_rdata[c_FIFO_W-1];
   assign m_axis_tuser  = w_fifo_rdata[DATA_W +: CNT_W];
   assign m_axis_tdata  = w_fifo_rdata[DATA_W-1:0];

   // ------------------------------------------------------------------------
   // Status / control outputs
   // ------------------------------------------------------------------------
   assign sync_short_rst_out = r_short_rst;
   assign sync_long_rst_out  = r_long_rst;
   assign short_en_out       = (r_state == SYNC_SHORT);
   assign long_en_out        = (r_state == SYNC_LONG);
   assign lts_ready_out      = (r_state == SYNC_LONG);
   assign state_out          = r_state;
   assign frame_cnt_out      = r_frame_cnt;
   assign drop_cnt_out       = r_drop_cnt;
   assign timeout_cnt_out    = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lts_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lts_capture_ctrl                                          |
// | Description : Directed self-checking bench for lts_capture_ctrl with       |
// |               default parameters (LTS_LEN 128, FIFO 256, timeout 320,      |
// |               holdoff 64).                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lts_capture_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        mode_in = 1'b0;
   logic        arm_in = 1'b0;
   logic        signal_valid_in = 1'b0;
   logic        power_trigger_in = 1'b0;
   logic        short_detected_in = 1'b0;
   logic        sync_short_rst_out;
   logic        sync_long_rst_out;
   logic        short_en_out;
   logic        long_en_out;
   logic        lts_valid_in = 1'b0;
   logic        lts_last_in = 1'b0;
   logic [31:0] lts_data_in = '0;
   logic        lts_ready_out;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic [31:0] m_axis_tdata;
   logic [15:0] m_axis_tuser;
   logic        m_axis_tready;
   logic [2:0]  state_out;
   logic [15:0] frame_cnt_out;
   logic [15:0] drop_cnt_out;
   logic [15:0] timeout_cnt_out;

   logic        tready_fix = 1'b0;
   logic        rand_on = 1'b0;
   logic        rnd_bit = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_idx = '0;
   logic [48:0] out_q[$];
   logic [48:0] exp_q[$];

   assign m_axis_tready = rand_on ? rnd_bit : tready_fix;

   lts_capture_ctrl dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .mode_in            (mode_in),
      .arm_in             (arm_in),
      .signal_valid_in    (signal_valid_in),
      .power_trigger_in   (power_trigger_in),
      .short_detected_in  (short_detected_in),
      .sync_short_rst_out (sync_short_rst_out),
      .sync_long_rst_out  (sync_long_rst_out),
      .short_en_out       (short_en_out),
      .long_en_out        (long_en_out),
      .lts_valid_in       (lts_valid_in),
      .lts_last_in        (lts_last_in),
      .lts_data_in        (lts_data_in),
      .lts_ready_out      (lts_ready_out),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tready      (m_axis_tready),
      .state_out          (state_out),
      .frame_cnt_out      (frame_cnt_out),
      .drop_cnt_out       (drop_cnt_out),
      .timeout_cnt_out    (timeout_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      forever begin
         @(posedge clk_in);
         #1 rnd_bit = 1'($urandom_range(0, 1));
      end
   end

   // Beats are recorded mid-cycle; the handshake completes at the next rising edge.
   always @(negedge clk_in) begin
      if (!rst_in && m_axis_tvalid && m_axis_tready) begin
         out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int n = 0;
      while (state_out !== s && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 64'(state_out), 64'(s));
   endtask

   task automatic wait_beats(input int target, input int budget);
      int n = 0;
      while (out_q.size() < target && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         chk(tag, 64'(out_q[i]), 64'(exp_q[i]));
      end
      out_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      exp_idx = '0;
      out_q.delete();
      exp_q.delete();
   endtask

   // One preamble: trigger, short pulse, then n words. drop_at >= 0 drops power
   // while that word index is presented. admit=0 means the frame must not appear.
   task automatic run_frame(input int n, input bit flag, input logic [31:0] base,
                            input int drop_at, input bit admit);
      logic lst;
      power_trigger_in = 1'b1;
      tick();
      short_detected_in = 1'b1;
      tick();
      short_detected_in = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == drop_at) power_trigger_in = 1'b0;
         lst = (flag && i == n - 1) || (i == 127);
         lts_valid_in = 1'b1;
         lts_last_in  = flag && (i == n - 1);
         lts_data_in  = base + 32'(i);
         if (admit) exp_q.push_back({lst, exp_idx, base + 32'(i)});
         tick();
      end
      lts_valid_in = 1'b0;
      lts_last_in  = 1'b0;
      power_trigger_in = 1'b0;
      if (admit) exp_idx = exp_idx + 16'd1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      tick();
      tick();
      rst_in = 1'b0;
      chk("rst_state", 64'(state_out), 64'd0);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_ready", 64'(lts_ready_out), 64'd0);
      chk("rst_pulses", 64'({sync_short_rst_out, sync_long_rst_out, short_en_out, long_en_out}), 64'd0);
      chk("rst_cnts", 64'({frame_cnt_out, drop_cnt_out, timeout_cnt_out}), 64'd0);

      // ---------------- single 64-word frame, tready=1 ----------------
      tready_fix = 1'b1;
      power_trigger_in = 1'b1;
      tick();
      chk("t1_state_short", 64'(state_out), 64'd1);
      chk("t1_short_rst", 64'(sync_short_rst_out), 64'd1);
      chk("t1_short_en", 64'(short_en_out), 64'd1);
      short_detected_in = 1'b1;
      tick();
      short_detected_in = 1'b0;
      chk("t1_state_long", 64'(state_out), 64'd2);
      chk("t1_long_rst", 64'(sync_long_rst_out), 64'd1);
      chk("t1_ready", 64'(lts_ready_out), 64'd1);
      chk("t1_short_rst_gone", 64'(sync_short_rst_out), 64'd0);
      chk("t1_tvalid_pre", 64'(m_axis_tvalid), 64'd0);
      for (int i = 0; i < 64; i++) begin
         lts_valid_in = 1'b1;
         lts_last_in  = (i == 63);
         lts_data_in  = 32'hA000_0000 + 32'(i);
         exp_q.push_back({(i == 63), 16'd0, 32'hA000_0000 + 32'(i)});
         tick();
         if (i == 0) begin
            chk("t1_latency_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("t1_latency_tdata", 64'(m_axis_tdata), 64'hA000_0000);
         end
      end
      lts_valid_in = 1'b0;
      lts_last_in  = 1'b0;
      power_trigger_in = 1'b0;
      exp_idx = 16'd1;
      chk("t1_state_hold", 64'(state_out), 64'd3);
      chk("t1_ready_off", 64'(lts_ready_out), 64'd0);
      wait_state("t1_back_idle", 3'd0, 100);
      chk("t1_frame_cnt", 64'(frame_cnt_out), 64'd1);
      check_stream("t1_stream");

      // ---------------- long-sync timeout ----------------
      power_trigger_in = 1'b1;
      tick();
      short_detected_in = 1'b1;
      tick();
      short_detected_in = 1'b0;
      signal_valid_in = 1'b1;
      for (int i = 0; i < 320; i++) tick();
      signal_valid_in = 1'b0;
      chk("t2_still_long", 64'(state_out), 64'd2);
      tick();
      chk("t2_hold", 64'(state_out), 64'd3);
      chk("t2_timeout_cnt", 64'(timeout_cnt_out), 64'd1);
      power_trigger_in = 1'b0;
      wait_state("t2_idle", 3'd0, 100);
      chk("t2_no_beats", 64'(out_q.size()), 64'd0);
      chk("t2_frame_cnt", 64'(frame_cnt_out), 64'd1);

      // ---------------- admission control, tready=0 ----------------
      do_reset();
      chk("t3_rst_cnts", 64'({frame_cnt_out, timeout_cnt_out}), 64'd0);
      tready_fix = 1'b0;
      run_frame(128, 1'b0, 32'hB000_0000, -1, 1'b1);
      wait_state("t3_f0_idle", 3'd0, 100);
      chk("t3_hold_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("t3_hold_tdata", 64'(m_axis_tdata), 64'hB000_0000);
      run_frame(128, 1'b0, 32'hB000_0100, -1, 1'b1);
      wait_state("t3_f1_idle", 3'd0, 100);
      run_frame(128, 1'b0, 32'hB000_0200, -1, 1'b0);
      wait_state("t3_f2_idle", 3'd0, 100);
      chk("t3_drop_cnt", 64'(drop_cnt_out), 64'd1);
      chk("t3_frame_cnt", 64'(frame_cnt_out), 64'd2);
      chk("t3_still_head", 64'({m_axis_tuser, m_axis_tdata}), 64'hB000_0000);
      tready_fix = 1'b1;
      wait_beats(256, 400);
      tick();
      tick();
      check_stream("t3_stream");

      // ---------------- single-shot ----------------
      do_reset();
      mode_in = 1'b1;
      run_frame(64, 1'b1, 32'hC000_0000, -1, 1'b1);
      wait_state("t4_done", 3'd4, 200);
      run_frame(64, 1'b1, 32'hC100_0000, -1, 1'b0);
      chk("t4_stay_done", 64'(state_out), 64'd4);
      chk("t4_one_frame", 64'(frame_cnt_out), 64'd1);
      arm_in = 1'b1;
      tick();
      arm_in = 1'b0;
      chk("t4_armed", 64'(state_out), 64'd0);
      run_frame(64, 1'b1, 32'hC200_0000, -1, 1'b1);
      wait_state("t4_done2", 3'd4, 200);
      chk("t4_two_frames", 64'(frame_cnt_out), 64'd2);
      check_stream("t4_stream");
      mode_in = 1'b0;
      arm_in = 1'b1;
      tick();
      arm_in = 1'b0;

      // ---------------- power drop during / before LTS ----------------
      run_frame(64, 1'b1, 32'hD000_0000, 10, 1'b1);
      wait_state("t5_idle", 3'd0, 200);
      chk("t5_frame_cnt", 64'(frame_cnt_out), 64'd3);
      check_stream("t5_stream");
      power_trigger_in = 1'b1;
      tick();
      short_detected_in = 1'b1;
      tick();
      short_detected_in = 1'b0;
      power_trigger_in = 1'b0;
      tick();
      chk("t5_early_abort", 64'(state_out), 64'd3);
      wait_state("t5_idle2", 3'd0, 100);
      chk("t5_nothing_written", 64'(m_axis_tvalid), 64'd0);
      chk("t5_frame_cnt2", 64'(frame_cnt_out), 64'd3);

      // ---------------- random backpressure over 10 frames ----------------
      rand_on = 1'b1;
      for (int f = 0; f < 10; f++) begin
         run_frame(16 + 9 * f, 1'b1, 32'hE000_0000 + 32'(f << 8), -1, 1'b1);
         wait_state("t6_idle", 3'd0, 200);
         for (int n = 0; n < 2000 && m_axis_tvalid; n++) tick();
      end
      rand_on = 1'b0;
      tready_fix = 1'b1;
      tick();
      tick();
      chk("t6_frame_cnt", 64'(frame_cnt_out), 64'd13);
      check_stream("t6_stream");

      // ---------------- reset mid-frame ----------------
      tready_fix = 1'b0;
      power_trigger_in = 1'b1;
      tick();
      short_detected_in = 1'b1;
      tick();
      short_detected_in = 1'b0;
      for (int i = 0; i < 30; i++) begin
         lts_valid_in = 1'b1;
         lts_data_in  = 32'hF000_0000 + 32'(i);
         tick();
      end
      chk("t7_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
      lts_valid_in = 1'b0;
      power_trigger_in = 1'b0;
      rst_in = 1'b1;
      tick();
      chk("t7_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t7_state", 64'(state_out), 64'd0);
      chk("t7_cnts", 64'({frame_cnt_out, drop_cnt_out, timeout_cnt_out}), 64'd0);
      rst_in = 1'b0;
      tick();
      chk("t7_no_beats", 64'(out_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
